pipe_perf_monitor: RTL

- Parametrised pipeline event monitor for the pipelined CPU. It generalises the bench-side stall/flush/cycle counting into synthesizable RTL.
- NUM_EVT independent event counters plus one run-cycle counter. Run window is bounded by MAX_CYCLES. Per-channel inhibit qualifiers, sticky overflow flags, and a registered read mux.
- Sits beside the CPU top. Event inputs are driven from hazard-detection stall, branch flush and write-back valid signals.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_counter.sv | 60 ++++++
 rtl/pipe_perf_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and helpers for the pipeline performance monitor
// Contents:
//   perf_state_e   : monitor state encoding (IDLE=00, RUN=01, DONE=10)
//   PERF_CNT_W_DEF : default counter width
//   perf_sel_w()   : readout select width for a given channel count (min 1)
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE = 2'b00,
    PERF_RUN  = 2'b01,
    PERF_DONE = 2'b10
  } perf_state_e;

  localparam int PERF_CNT_W_DEF = 32;

  function automatic int perf_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - one event counter channel with sticky overflow flag
// Optional build macro: PERF_SAT_EN (saturate at all-ones instead of wrapping)
// Ports:
//   clk_i      in   clock
//   rst_n_i    in   asynchronous active-low reset
//   clr_i      in   synchronous clear of count and flag (wins over inc_i)
//   inc_i      in   count one this cycle
//   cnt_nxt_o  out  CNT_W value the counter takes at the coming edge
//   ovf_o      out  sticky overflow flag
module perf_counter #(
  parameter int CNT_W = perf_pkg::PERF_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
`ifdef PERF_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The readout register captures the post-edge value, so expose the next value.
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline event monitor: run FSM, cycle counter, event channels, readout
// Optional build macro: PERF_SAT_EN (event and cycle counters saturate)
// Ports:
//   clk_i     in   clock
//   rst_n_i   in   asynchronous active-low reset
//   start_i   in   level start request, honoured in IDLE only
//   clr_i     in   synchronous clear to IDLE, highest priority
//   freeze_i  in   suspend event counting in RUN (cycle counter keeps going)
//   evt_i     in   per-channel event strobes
//   inh_i     in   per-channel inhibits
//   rd_sel_i  in   readout channel select
//   rd_val_o  out  registered value of the selected channel (0 when out of range)
//   cycle_o   out  run-cycle counter
//   state_o   out  00 IDLE, 01 RUN, 10 DONE
//   done_o    out  high in DONE
//   ovf_o     out  sticky per-channel overflow flags
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = PERF_CNT_W_DEF,
  parameter int MAX_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             start_i,
  input  logic                             clr_i,
  input  logic                             freeze_i,
  input  logic [NUM_EVT-1:0]               evt_i,
  input  logic [NUM_EVT-1:0]               inh_i,
  input  logic [perf_sel_w(NUM_EVT)-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]                 rd_val_o,
  output logic [CNT_W-1:0]                 cycle_o,
  output logic [1:0]                       state_o,
  output logic                             done_o,
  output logic [NUM_EVT-1:0]               ovf_o
);

  localparam int               SEL_W = perf_sel_w(NUM_EVT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  // Only meaningful when MAX_CYCLES != 0; the compare below is gated on that.
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_CYCLES - 1);

  perf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] rd_val_q, rd_mux;
  logic [CNT_W-1:0] cnt_nxt [NUM_EVT];
  logic [NUM_EVT-1:0] inc;

  wire run = (state_q == PERF_RUN);

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    case (state_q)
      PERF_IDLE: if (start_i) state_d = PERF_RUN;
      PERF_RUN: begin
`ifdef PERF_SAT_EN
        if (!(&cycle_q)) cycle_d = cycle_q + ONE;
`else
        cycle_d = cycle_q + ONE;
`endif
        if ((MAX_CYCLES != 0) && (cycle_q == LAST)) state_d = PERF_DONE;
      end
      PERF_DONE: state_d = PERF_DONE;
      default:   state_d = PERF_IDLE;
    endcase
    if (clr_i) begin
      state_d = PERF_IDLE;
      cycle_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= PERF_IDLE;
      cycle_q  <= '0;
      rd_val_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      rd_val_q <= rd_mux;
    end
  end

  // Counting happens only on edges taken while already in RUN, so the
  // IDLE->RUN edge counts nothing and the RUN->DONE edge still counts.
  assign inc = evt_i & ~inh_i & {NUM_EVT{run & ~freeze_i}};

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_chan
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (clr_i),
      .inc_i     (inc[k]),
      .cnt_nxt_o (cnt_nxt[k]),
      .ovf_o     (ovf_o[k])
    );
  end

  // Selects with no matching channel fall through to 0.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = cnt_nxt[k];
    end
  end

  assign rd_val_o = rd_val_q;
  assign cycle_o  = cycle_q;
  assign state_o  = state_q;
  assign done_o   = (state_q == PERF_DONE);

endmodule
